// File: rtl/tpa_regspace_arb.sv
// tpa_regspace_arb: serial-priority arbiter over a shared register file.
// Define TPA_PARITY_EN to add parity bits to serial write and read frames.
module tpa_regspace_arb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sda_in,
  output logic              sda_out,
  output logic              sda_oe,
  input  logic              cfg_req,
  input  logic              cfg_cmd,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  output logic              cfg_rdy,
  output logic [DATA_W-1:0] cfg_rdata,
  output logic              serial_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int MAXW  = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
  localparam int MAXW4 = (MAXW > 4) ? MAXW : 4;
  localparam int CNT_W = $clog2(MAXW4);
  localparam int DI_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WDATA,
`ifdef TPA_PARITY_EN
    S_WPAR,
    S_RPAR,
`endif
    S_WR,
    S_TURN,
    S_RDATA,
    S_STOP
  } s_state_t;

  typedef enum logic {
    P_IDLE,
    P_DONE
  } p_state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  s_state_t          s_q, s_d;
  p_state_t          p_q, p_d;
  logic [CNT_W-1:0]  cnt;
  logic              cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rd_word;
  logic              grant;
  logic              s_wr;

  assign rd_word = mem[addr_q];
  assign s_wr    = (s_q == S_WR);
  assign grant   = (p_q == P_IDLE) && cfg_req &&
                   ((s_q == S_IDLE) || (s_q == S_CMD));

`ifdef TPA_PARITY_EN
  logic par_bad;
  logic err_q;
  assign par_bad    = ^{cmd_q, addr_q, wdata_q, sda_in};
  assign serial_err = err_q;
`else
  assign serial_err = 1'b0;
`endif

  always_comb begin
    s_d = s_q;
    unique case (s_q)
      S_IDLE:  if (!sda_in) s_d = S_CMD;
      S_CMD:   s_d = S_ADDR;
      S_ADDR:
        if (cnt == CNT_W'(ADDR_W - 1))
          s_d = cmd_q ? S_WDATA : S_TURN;
      S_WDATA:
        if (cnt == CNT_W'(DATA_W - 1))
`ifdef TPA_PARITY_EN
          s_d = S_WPAR;
      S_WPAR:  s_d = par_bad ? S_IDLE : S_WR;
`else
          s_d = S_WR;
`endif
      S_WR:    s_d = S_IDLE;
      S_TURN:  if (cnt == CNT_W'(3)) s_d = S_RDATA;
      S_RDATA:
        if (cnt == CNT_W'(DATA_W - 1))
`ifdef TPA_PARITY_EN
          s_d = S_RPAR;
      S_RPAR:  s_d = S_STOP;
`else
          s_d = S_STOP;
`endif
      S_STOP:  if (cnt == CNT_W'(1)) s_d = S_IDLE;
      default: s_d = S_IDLE;
    endcase
  end

  // Pad drive is decoded straight from state so read bits track the array.
  always_comb begin
    sda_oe  = 1'b0;
    sda_out = 1'b0;
    unique case (s_q)
      S_TURN: begin
        if (cnt == CNT_W'(2)) begin
          sda_oe  = 1'b1;
          sda_out = 1'b1;
        end else if (cnt == CNT_W'(3)) begin
          sda_oe  = 1'b1;
        end
      end
      S_RDATA: begin
        sda_oe  = 1'b1;
        sda_out = rd_word[cnt[DI_W-1:0]];
      end
`ifdef TPA_PARITY_EN
      S_RPAR: begin
        sda_oe  = 1'b1;
        sda_out = ^rd_word;
      end
`endif
      S_STOP: begin
        if (cnt == CNT_W'(0)) begin
          sda_oe  = 1'b1;
          sda_out = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s_q     <= S_IDLE;
      cnt     <= '0;
      cmd_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef TPA_PARITY_EN
      err_q   <= 1'b0;
`endif
    end else begin
      s_q <= s_d;
      cnt <= (s_d != s_q) ? '0 : cnt + 1'b1;
      if (s_q == S_CMD)
        cmd_q <= sda_in;
      if (s_q == S_ADDR)
        addr_q <= {sda_in, addr_q[ADDR_W-1:1]};
      if (s_q == S_WDATA)
        wdata_q <= {sda_in, wdata_q[DATA_W-1:1]};
`ifdef TPA_PARITY_EN
      err_q <= (s_q == S_WPAR) && par_bad;
`endif
    end
  end

  always_comb begin
    p_d = p_q;
    unique case (p_q)
      P_IDLE:  if (grant) p_d = P_DONE;
      P_DONE:  p_d = P_IDLE;
      default: p_d = P_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      p_q     <= P_IDLE;
      rdata_q <= '0;
    end else begin
      p_q <= p_d;
      if (grant && !cfg_cmd)
        rdata_q <= mem[cfg_addr];
    end
  end

  // Serial WR and a parallel grant can never coincide.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (s_wr)
        mem[addr_q] <= wdata_q;
      else if (grant && cfg_cmd)
        mem[cfg_addr] <= cfg_wdata;
    end
  end

  assign cfg_rdy   = (p_q == P_DONE);
  assign cfg_rdata = rdata_q;

endmodule

// File: tb/tb_tpa_regspace_arb.sv
// tb_tpa_regspace_arb: directed scenarios for tpa_regspace_arb.
// Honors TPA_PARITY_EN for frame lengths and the parity scenario.
module tb_tpa_regspace_arb;

  localparam int DW = 16;
  localparam int AW = 8;
`ifdef TPA_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          sda_in;
  logic          sda_out;
  logic          sda_oe;
  logic          cfg_req;
  logic          cfg_cmd;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_wdata;
  logic          cfg_rdy;
  logic [DW-1:0] cfg_rdata;
  logic          serial_err;

  int checks = 0;
  int fails  = 0;

  tpa_regspace_arb #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sda_in     (sda_in),
    .sda_out    (sda_out),
    .sda_oe     (sda_oe),
    .cfg_req    (cfg_req),
    .cfg_cmd    (cfg_cmd),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_rdy    (cfg_rdy),
    .cfg_rdata  (cfg_rdata),
    .serial_err (serial_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sda_in = b;
    tick();
  endtask

  task automatic serial_write(input logic [AW-1:0] a,
                              input logic [DW-1:0] d,
                              input logic good);
    logic exp_err;
    send_bit(1'b0);
    send_bit(1'b1);
    for (int i = 0; i < AW; i++) send_bit(a[i]);
    for (int j = 0; j < DW; j++) send_bit(d[j]);
    if (PAR != 0) send_bit((^{1'b1, a, d}) ^ !good);
    sda_in = 1'b1;
    exp_err = (PAR != 0) && !good;
    @(negedge clk);
    checks++;
    if (serial_err !== exp_err) begin
      $display("FAIL serial_err_pulse got=%b exp=%b", serial_err, exp_err);
      fails++;
    end
    tick();
    @(negedge clk);
    checks++;
    if (serial_err !== 1'b0) begin
      $display("FAIL serial_err_end got=%b exp=0", serial_err);
      fails++;
    end
    tick();
  endtask

  task automatic serial_read(input logic [AW-1:0] a,
                             input logic [DW-1:0] d);
    logic [3:0]    toe, tout;
    logic [DW-1:0] doe, dat;
    logic          poe, pb, soe0, sout0, soe1;
    send_bit(1'b0);
    send_bit(1'b0);
    for (int i = 0; i < AW; i++) send_bit(a[i]);
    sda_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      toe[k]  = sda_oe;
      tout[k] = sda_out;
      tick();
    end
    for (int j = 0; j < DW; j++) begin
      @(negedge clk);
      doe[j] = sda_oe;
      dat[j] = sda_out;
      tick();
    end
    poe = 1'b1;
    pb  = ^d;
    if (PAR != 0) begin
      @(negedge clk);
      poe = sda_oe;
      pb  = sda_out;
      tick();
    end
    @(negedge clk);
    soe0  = sda_oe;
    sout0 = sda_out;
    tick();
    @(negedge clk);
    soe1 = sda_oe;
    tick();
    checks++;
    if (toe !== 4'b1100) begin
      $display("FAIL turn_oe got=%b exp=1100", toe);
      fails++;
    end
    checks++;
    if (tout[3:2] !== 2'b01) begin
      $display("FAIL turn_bits got=%b exp=01", tout[3:2]);
      fails++;
    end
    checks++;
    if (doe !== {DW{1'b1}}) begin
      $display("FAIL rdata_oe got=%h exp=%h", doe, {DW{1'b1}});
      fails++;
    end
    checks++;
    if (dat !== d) begin
      $display("FAIL serial_rdata got=%h exp=%h", dat, d);
      fails++;
    end
    checks++;
    if ({poe, pb} !== {1'b1, ^d}) begin
      $display("FAIL rpar got=%b%b exp=1%b", poe, pb, ^d);
      fails++;
    end
    checks++;
    if ({soe0, sout0, soe1} !== 3'b110) begin
      $display("FAIL stop got=%b%b%b exp=110", soe0, sout0, soe1);
      fails++;
    end
  endtask

  task automatic cfg_access(input logic cmd,
                            input logic [AW-1:0] a,
                            input logic [DW-1:0] wd,
                            input logic [DW-1:0] exp_rd,
                            input int exp_lat);
    int n = 0;
    cfg_req   = 1'b1;
    cfg_cmd   = cmd;
    cfg_addr  = a;
    cfg_wdata = wd;
    while (n < 100) begin
      tick();
      n++;
      @(negedge clk);
      if (cfg_rdy) break;
    end
    checks++;
    if (n !== exp_lat) begin
      $display("FAIL cfg_latency got=%0d exp=%0d", n, exp_lat);
      fails++;
    end
    if (!cmd) begin
      checks++;
      if (cfg_rdata !== exp_rd) begin
        $display("FAIL cfg_rdata got=%h exp=%h", cfg_rdata, exp_rd);
        fails++;
      end
    end
    tick();
    cfg_req = 1'b0;
    @(negedge clk);
    checks++;
    if (cfg_rdy !== 1'b0) begin
      $display("FAIL cfg_rdy_pulse got=%b exp=0", cfg_rdy);
      fails++;
    end
    tick();
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    sda_in    = 1'b1;
    cfg_req   = 1'b0;
    cfg_cmd   = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({sda_oe, sda_out, cfg_rdy, serial_err, cfg_rdata} !== '0) begin
      $display("FAIL reset_outputs got=%b%b%b%b_%h exp=0",
               sda_oe, sda_out, cfg_rdy, serial_err, cfg_rdata);
      fails++;
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_parallel();
    cfg_access(1'b1, 8'h3C, 16'hBEEF, 16'h0000, 1);
    cfg_access(1'b0, 8'h3C, 16'h0000, 16'hBEEF, 1);
  endtask

  task automatic test_serial();
    serial_write(8'h05, 16'h1234, 1'b1);
    serial_read(8'h05, 16'h1234);
    cfg_access(1'b0, 8'h05, 16'h0000, 16'h1234, 1);
  endtask

  task automatic test_stall();
    fork
      serial_write(8'h05, 16'h4321, 1'b1);
      begin
        tick();
        tick();
        tick();
        cfg_access(1'b0, 8'h05, 16'h0000, 16'h4321, 25 + PAR);
      end
    join
  endtask

  task automatic test_same_cycle();
    fork
      serial_read(8'h10, 16'hAAAA);
      cfg_access(1'b1, 8'h10, 16'hAAAA, 16'h0000, 1);
    join
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] a = 8'h05;
    logic [DW-1:0] d = 16'h0F0F;
    send_bit(1'b0);
    send_bit(1'b1);
    for (int i = 0; i < AW; i++) send_bit(a[i]);
    for (int j = 0; j < 5; j++) send_bit(d[j]);
    reset_n = 1'b0;
    sda_in  = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if ({sda_oe, sda_out, cfg_rdy, serial_err, cfg_rdata} !== '0) begin
      $display("FAIL midreset_outputs got=%b%b%b%b_%h exp=0",
               sda_oe, sda_out, cfg_rdy, serial_err, cfg_rdata);
      fails++;
    end
    reset_n = 1'b1;
    tick();
    cfg_access(1'b0, 8'h05, 16'h0000, 16'h4321, 1);
    serial_write(8'h05, 16'h0F0F, 1'b1);
    serial_read(8'h05, 16'h0F0F);
  endtask

`ifdef TPA_PARITY_EN
  task automatic test_parity();
    serial_write(8'h20, 16'h1111, 1'b1);
    serial_write(8'h20, 16'h2222, 1'b0);
    cfg_access(1'b0, 8'h20, 16'h0000, 16'h1111, 1);
    serial_write(8'h20, 16'h2222, 1'b1);
    serial_read(8'h20, 16'h2222);
  endtask
`endif

  initial begin
    test_reset();
    test_parallel();
    test_serial();
    test_stall();
    test_same_cycle();
    test_reset_mid();
`ifdef TPA_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
